// File: rtl/top.sv
// top: memory-backed arithmetic engine (reciprocal, fractional divide, sqrt).
// Ports: CLK clock; START sync reset/launch (run on fall); DONE results stored.

module data_mem #(
  parameter int DEPTH = 256
) (
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [7:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] raddr_i,
  output logic [7:0] rdata_o
);
  logic [7:0] MyMemory [0:DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (we_i) MyMemory[waddr_i] <= wdata_i;
  end

  assign rdata_o = MyMemory[raddr_i];
endmodule

module top #(
  parameter int MEM_DEPTH   = 256,
  parameter int MAX_LATENCY = 2000
) (
  input  logic CLK,
  input  logic START,
  output logic DONE
);
  localparam int WORST_LAT = 40;

  if (MEM_DEPTH != 256) begin : g_bad_depth
    $error("top: byte addresses are 8 bits, MEM_DEPTH must be 256");
  end
  if (MAX_LATENCY < WORST_LAT) begin : g_bad_lat
    $error("top: MAX_LATENCY below worst-case run length");
  end

  typedef enum logic [2:0] {
    IDLE, LOAD, CALC, ROUND, STORE, FIN
  } state_t;

  state_t      state_q, state_d;
  // Holds JOB-1, so the all-zero power-up state selects job 1.
  logic [1:0]  job_q, job_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] op_q, op_d;
  logic [24:0] dvd_q, dvd_d;
  logic [15:0] div_q, div_d;
  logic [24:0] quo_q, quo_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] sx_q, sx_d;
  logic [7:0]  root_q, root_d;
  logic [9:0]  srem_q, srem_d;
  logic [23:0] res_q, res_d;

  logic        mem_we;
  logic [7:0]  mem_waddr, mem_raddr, mem_wdata, mem_rdata;

  logic        is_j2, is_j3;
  logic [7:0]  ld_base, st_base;
  logic [4:0]  ld_last, st_last, calc_last;
  logic [1:0]  job_nxt;

  logic [16:0] d_trial;
  logic [11:0] s_trial;
  logic [15:0] ld_val;
  logic [15:0] r16;
  logic [23:0] r24;
  logic        sq_up;
  logic [7:0]  r8;

  data_mem #(
    .DEPTH(MEM_DEPTH)
  ) MyDataMem (
    .clk_i  (CLK),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .raddr_i(mem_raddr),
    .rdata_o(mem_rdata)
  );

  assign is_j2 = (job_q == 2'd1);
  assign is_j3 = (job_q == 2'd2);

  always_comb begin
    ld_base   = 8'd8;
    ld_last   = 5'd1;
    st_base   = 8'd10;
    st_last   = 5'd1;
    calc_last = 5'd24;
    job_nxt   = 2'd1;
    unique case (1'b1)
      is_j2: begin
        ld_base = 8'd0;
        ld_last = 5'd2;
        st_base = 8'd4;
        st_last = 5'd2;
        job_nxt = 2'd2;
      end
      is_j3: begin
        ld_base   = 8'd13;
        st_base   = 8'd15;
        st_last   = 5'd0;
        calc_last = 5'd7;
        job_nxt   = 2'd0;
      end
      default: ;
    endcase
  end

  assign mem_raddr = ld_base + {3'd0, cnt_q};
  assign mem_waddr = st_base + {3'd0, cnt_q};
  assign mem_wdata = res_q[23:16];

  // Operand bytes arrive MSB first; the last byte is still on the read port.
  assign ld_val  = {op_q[7:0], mem_rdata};
  assign d_trial = {rem_q, dvd_q[24]};
  assign s_trial = {srem_q, sx_q[15:14]};

  // Quotient LSB is the half bit below the kept result.
  assign r16   = quo_q[16:1] + {15'd0, quo_q[0]};
  assign r24   = quo_q[24:1] + {23'd0, quo_q[0]};
  // X - r*r > r  <=>  X > r*r + r
  assign sq_up = (srem_q > {2'b00, root_q});
  assign r8    = (sq_up && root_q != 8'hFF) ? root_q + 8'd1 : root_q;

  always_comb begin
    state_d = state_q;
    job_d   = job_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    sx_d    = sx_q;
    root_d  = root_q;
    srem_d  = srem_q;
    res_d   = res_q;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = LOAD;
        cnt_d   = 5'd0;
      end
      LOAD: begin
        op_d  = ld_val;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == ld_last) begin
          cnt_d   = 5'd0;
          rem_d   = 16'd0;
          quo_d   = 25'd0;
          srem_d  = 10'd0;
          root_d  = 8'd0;
          state_d = CALC;
          unique case (1'b1)
            is_j3: sx_d = ld_val;
            is_j2: begin
              dvd_d = {op_q, 9'd0};
              div_d = {8'd0, mem_rdata};
              if (mem_rdata == 8'd0) begin
                res_d   = 24'hFFFFFF;
                state_d = STORE;
              end
            end
            default: begin
              // 2^16 / D keeps the result plus its round bit.
              dvd_d = 25'h0010000;
              div_d = ld_val;
              if (ld_val == 16'd0) begin
                res_d   = {16'hFFFF, 8'h00};
                state_d = STORE;
              end
            end
          endcase
        end
      end
      CALC: begin
        if (is_j3) begin
          sx_d = {sx_q[13:0], 2'b00};
          if (s_trial >= {2'b00, root_q, 2'b01}) begin
            srem_d = s_trial[9:0] - {root_q, 2'b01};
            root_d = {root_q[6:0], 1'b1};
          end else begin
            srem_d = s_trial[9:0];
            root_d = {root_q[6:0], 1'b0};
          end
        end else begin
          dvd_d = {dvd_q[23:0], 1'b0};
          if (d_trial >= {1'b0, div_q}) begin
            rem_d = d_trial[15:0] - div_q;
            quo_d = {quo_q[23:0], 1'b1};
          end else begin
            rem_d = d_trial[15:0];
            quo_d = {quo_q[23:0], 1'b0};
          end
        end
        if (cnt_q == calc_last) begin
          state_d = ROUND;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ROUND: begin
        state_d = STORE;
        cnt_d   = 5'd0;
        unique case (1'b1)
          is_j3:   res_d = {r8, 16'h0000};
          is_j2:   res_d = r24;
          default: res_d = {r16, 8'h00};
        endcase
      end
      STORE: begin
        mem_we = 1'b1;
        res_d  = {res_q[15:0], 8'h00};
        if (cnt_q == st_last) begin
          state_d = FIN;
          job_d   = job_nxt;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      FIN: ;
      default: state_d = IDLE;
    endcase

    // An abort must not land a partial result.
    if (START) mem_we = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (START) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
    end
    cnt_q  <= cnt_d;
    op_q   <= op_d;
    dvd_q  <= dvd_d;
    div_q  <= div_d;
    quo_q  <= quo_d;
    rem_q  <= rem_d;
    sx_q   <= sx_d;
    root_q <= root_d;
    srem_q <= srem_d;
    res_q  <= res_d;
  end

  assign DONE = (state_q == FIN) && !START;
endmodule

// File: tb/tb_top.sv
// tb_top: directed bench for top; preloads MyDataMem, runs the job rotation,
// compares bytes 0..31 against a shadow image after each run.

module tb_top;
  localparam int MAXLAT = 2000;

  logic CLK   = 1'b0;
  logic START = 1'b1;
  logic DONE;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sh [0:31];

  logic [15:0] j1d [6] = '{16'h0001, 16'h0003, 16'h0000,
                           16'hFFFF, 16'h1234, 16'h0002};
  logic [15:0] j1r [6] = '{16'h8000, 16'h2AAB, 16'hFFFF,
                           16'h0001, 16'h0007, 16'h4000};
  logic [15:0] j2n [6] = '{16'h0001, 16'hFFFF, 16'hFFFF,
                           16'h0001, 16'h0005, 16'h0002};
  logic [7:0]  j2d [6] = '{8'h03, 8'hFF, 8'h01, 8'h00, 8'h07, 8'h07};
  logic [23:0] j2r [6] = '{24'h000055, 24'h010100, 24'hFFFF00,
                           24'hFFFFFF, 24'h0000B7, 24'h000049};
  logic [15:0] j3x [6] = '{16'h0000, 16'h0002, 16'h0003,
                           16'h0010, 16'hFFFF, 16'hFE01};
  logic [7:0]  j3r [6] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'hFF, 8'hFF};

  always #5 CLK = ~CLK;

  top #(
    .MEM_DEPTH  (256),
    .MAX_LATENCY(MAXLAT)
  ) dut (
    .CLK  (CLK),
    .START(START),
    .DONE (DONE)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] v);
    dut.MyDataMem.MyMemory[a] = v;
    sh[a] = v;
  endtask

  task automatic mem_cmp(input string tag);
    for (int a = 0; a < 32; a++)
      chk($sformatf("%s_m%0d", tag, a),
          {24'd0, dut.MyDataMem.MyMemory[a]}, {24'd0, sh[a]});
  endtask

  task automatic run(input string tag);
    bit seen;
    START = 1'b1;
    @(negedge CLK);
    chk({tag, "_done_lo0"}, {31'd0, DONE}, 32'd0);
    @(negedge CLK);
    chk({tag, "_done_lo1"}, {31'd0, DONE}, 32'd0);
    START = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < MAXLAT && !seen; n++) begin
      @(negedge CLK);
      if (DONE) seen = 1'b1;
    end
    chk({tag, "_done_in_time"}, {31'd0, seen}, 32'd1);
    @(negedge CLK);
    chk({tag, "_done_hold"}, {31'd0, DONE}, 32'd1);
    mem_cmp(tag);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    for (int a = 0; a < 32; a++) wr(a, 8'(a * 13 + 7));
    mem_cmp("init");

    for (int k = 0; k < 6; k++) begin
      wr(8, j1d[k][15:8]);
      wr(9, j1d[k][7:0]);
      sh[10] = j1r[k][15:8];
      sh[11] = j1r[k][7:0];
      run($sformatf("j1_%0d", k));

      wr(0, j2n[k][15:8]);
      wr(1, j2n[k][7:0]);
      wr(2, j2d[k]);
      sh[4] = j2r[k][23:16];
      sh[5] = j2r[k][15:8];
      sh[6] = j2r[k][7:0];
      run($sformatf("j2_%0d", k));

      wr(13, j3x[k][15:8]);
      wr(14, j3x[k][7:0]);
      sh[15] = j3r[k];
      run($sformatf("j3_%0d", k));
    end

    // Abort a job 1 run mid-CALC; the prior 4000 result must survive.
    wr(8, 8'h00);
    wr(9, 8'h03);
    START = 1'b1;
    repeat (2) @(negedge CLK);
    START = 1'b0;
    repeat (10) @(negedge CLK);
    START = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk($sformatf("abort_done_lo%0d", i), {31'd0, DONE}, 32'd0);
    end
    mem_cmp("abort");

    // The retried run must still be job 1.
    sh[10] = 8'h2A;
    sh[11] = 8'hAB;
    run("retry_j1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
